// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for one TDC channel: arms capture, times start->stop in
// coarse clock cycles, latches fine codes and hands a result word to readout.
module tdc_meas_ctrl #(
    parameter int COARSE_W  = 16,
    parameter int FINE_W    = 7,
    parameter int TIMEOUT   = 50000,
    parameter int CAL_EVERY = 256
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                start_req,
    output logic                busy,
    output logic                tdc_arm,
    output logic                tdc_clr,
    output logic                cal_sel,
    input  logic                hit_start,
    input  logic [FINE_W-1:0]   fine_start,
    input  logic                hit_stop,
    input  logic [FINE_W-1:0]   fine_stop,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [COARSE_W-1:0] res_coarse,
    output logic [FINE_W-1:0]   res_fine_start,
    output logic [FINE_W-1:0]   res_fine_stop,
    output logic                res_cal,
    output logic                res_timeout,
    output logic [2:0]          dbg_state
);

    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int CAL_W = (CAL_EVERY > 1) ? $clog2(CAL_EVERY) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CAL_EVERY - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ARM        = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_STOP  = 3'd3,
        S_HOLD       = 3'd4,
        S_CLEAR      = 3'd5
    } state_t;

    // Result handshake: a word is transferred on the rising edge where res_valid
    // and res_ready are both 1; res_* stay frozen from the cycle res_valid rises
    // until that edge, and res_valid is held regardless of res_ready.

    state_t                r_state;
    state_t                w_next_state;
    logic [CAL_W-1:0]      r_meas_cnt;
    logic [TMO_W-1:0]      r_tmo_cnt;
    logic [COARSE_W-1:0]   r_coarse;
    logic [FINE_W-1:0]     r_fs_cap;
    logic                  r_tdc_arm;
    logic                  r_tdc_clr;
    logic                  r_cal_sel;
    logic                  r_res_valid;
    logic [COARSE_W-1:0]   r_res_coarse;
    logic [FINE_W-1:0]     r_res_fs;
    logic [FINE_W-1:0]     r_res_fp;
    logic                  r_res_cal;
    logic                  r_res_timeout;

    logic                  w_tmo_hit;
    logic                  w_sat;
    logic                  w_fin;
    logic                  w_fin_tmo;
    logic [COARSE_W-1:0]   w_fin_coarse;
    logic [FINE_W-1:0]     w_fin_fs;
    logic [FINE_W-1:0]     w_fin_fp;

    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
    assign w_sat     = &r_coarse;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_fin        = 1'b0;
        w_fin_tmo    = 1'b0;
        w_fin_coarse = '0;
        w_fin_fs     = '0;
        w_fin_fp     = '0;
        case (r_state)
            S_IDLE: begin
                if (start_req) w_next_state = S_ARM;
            end
            S_ARM: begin
                w_next_state = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (hit_start && hit_stop) begin
                    w_fin        = 1'b1;
                    w_fin_fs     = fine_start;
                    w_fin_fp     = fine_stop;
                    w_next_state = S_HOLD;
                end else if (hit_start) begin
                    w_next_state = S_WAIT_STOP;
                end else if (w_tmo_hit) begin
                    w_fin        = 1'b1;
                    w_fin_tmo    = 1'b1;
                    w_next_state = S_HOLD;
                end
            end
            S_WAIT_STOP: begin
                // A saturated coarse count cannot represent coarse+1, so it aborts even with a stop hit.
                if (hit_stop && !w_sat) begin
                    w_fin        = 1'b1;
                    w_fin_coarse = r_coarse + COARSE_W'(1);
                    w_fin_fs     = r_fs_cap;
                    w_fin_fp     = fine_stop;
                    w_next_state = S_HOLD;
                end else if (w_tmo_hit || w_sat) begin
                    w_fin        = 1'b1;
                    w_fin_tmo    = 1'b1;
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) w_next_state = S_CLEAR;
            end
            S_CLEAR: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_meas_cnt    <= '0;
            r_tmo_cnt     <= '0;
            r_coarse      <= '0;
            r_fs_cap      <= '0;
            r_tdc_arm     <= 1'b0;
            r_tdc_clr     <= 1'b0;
            r_cal_sel     <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_coarse  <= '0;
            r_res_fs      <= '0;
            r_res_fp      <= '0;
            r_res_cal     <= 1'b0;
            r_res_timeout <= 1'b0;
        end else begin
            r_tdc_clr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_req) r_cal_sel <= (r_meas_cnt == CAL_LAST);
                end
                S_ARM: begin
                    r_tdc_arm <= 1'b1;
                    r_tmo_cnt <= '0;
                end
                S_WAIT_START: begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    if (hit_start) begin
                        r_fs_cap <= fine_start;
                        r_coarse <= '0;
                    end
                end
                S_WAIT_STOP: begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    r_coarse  <= r_coarse + COARSE_W'(1);
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_tdc_clr   <= 1'b1;
                        r_cal_sel   <= 1'b0;
                        r_meas_cnt  <= (r_meas_cnt == CAL_LAST) ? '0 : r_meas_cnt + CAL_W'(1);
                    end
                end
                default: begin
                end
            endcase
            if (w_fin) begin
                r_tdc_arm     <= 1'b0;
                r_res_valid   <= 1'b1;
                r_res_coarse  <= w_fin_coarse;
                r_res_fs      <= w_fin_fs;
                r_res_fp      <= w_fin_fp;
                r_res_cal     <= r_cal_sel;
                r_res_timeout <= w_fin_tmo;
            end
        end
    end

    assign busy           = (r_state != S_IDLE);
    assign tdc_arm        = r_tdc_arm;
    assign tdc_clr        = r_tdc_clr;
    assign cal_sel        = r_cal_sel;
    assign res_valid      = r_res_valid;
    assign res_coarse     = r_res_coarse;
    assign res_fine_start = r_res_fs;
    assign res_fine_stop  = r_res_fp;
    assign res_cal        = r_res_cal;
    assign res_timeout    = r_res_timeout;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed, table-driven bench for tdc_meas_ctrl (COARSE_W=4, TIMEOUT=20,
// CAL_EVERY=4) plus a hand-written async-reset sequence.
module tb_tdc_meas_ctrl;

    localparam int CW = 4;
    localparam int FW = 7;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          start_req;
    logic          busy;
    logic          tdc_arm;
    logic          tdc_clr;
    logic          cal_sel;
    logic          hit_start;
    logic [FW-1:0] fine_start;
    logic          hit_stop;
    logic [FW-1:0] fine_stop;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] res_coarse;
    logic [FW-1:0] res_fine_start;
    logic [FW-1:0] res_fine_stop;
    logic          res_cal;
    logic          res_timeout;
    logic [2:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    int n_model = 0;

    tdc_meas_ctrl #(
        .COARSE_W(CW), .FINE_W(FW), .TIMEOUT(20), .CAL_EVERY(4)
    ) dut (
        .clk_in(clk_in), .rst(rst), .start_req(start_req), .busy(busy),
        .tdc_arm(tdc_arm), .tdc_clr(tdc_clr), .cal_sel(cal_sel),
        .hit_start(hit_start), .fine_start(fine_start),
        .hit_stop(hit_stop), .fine_stop(fine_stop),
        .res_valid(res_valid), .res_ready(res_ready), .res_coarse(res_coarse),
        .res_fine_start(res_fine_start), .res_fine_stop(res_fine_stop),
        .res_cal(res_cal), .res_timeout(res_timeout), .dbg_state(dbg_state)
    );

    always #5 clk_in = ~clk_in;

    // k counts cycles from the first WAIT_START cycle; -1 means no pulse.
    typedef struct {
        int            t_start;
        int            t_stop;
        int            t_xtra;
        logic [FW-1:0] fs;
        logic [FW-1:0] fp;
        int            bp;
        int            exp_lat;
        logic [CW-1:0] exp_coarse;
        logic [FW-1:0] exp_fs;
        logic [FW-1:0] exp_fp;
        logic          exp_tmo;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   k;
        bit   seen;
        logic exp_cal;
        v = vecs[i];
        exp_cal = (n_model == 3);
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        chk($sformatf("v%0d arm busy", i), busy, 1);
        chk($sformatf("v%0d arm cal_sel", i), cal_sel, exp_cal);
        chk($sformatf("v%0d arm tdc_arm", i), tdc_arm, 0);
        step();
        chk($sformatf("v%0d wait tdc_arm", i), tdc_arm, 1);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            hit_start  = (k == v.t_start) || (k == v.t_xtra);
            hit_stop   = (k == v.t_stop);
            fine_start = (k == v.t_start) ? v.fs : FW'($urandom_range(0, 127));
            fine_stop  = (k == v.t_stop) ? v.fp : FW'($urandom_range(0, 127));
            step();
            k++;
            hit_start = 1'b0;
            hit_stop  = 1'b0;
            seen = res_valid;
        end
        chk($sformatf("v%0d latency", i), k, v.exp_lat);
        chk($sformatf("v%0d res_coarse", i), res_coarse, v.exp_coarse);
        chk($sformatf("v%0d res_fine_start", i), res_fine_start, v.exp_fs);
        chk($sformatf("v%0d res_fine_stop", i), res_fine_stop, v.exp_fp);
        chk($sformatf("v%0d res_timeout", i), res_timeout, v.exp_tmo);
        chk($sformatf("v%0d res_cal", i), res_cal, exp_cal);
        chk($sformatf("v%0d hold tdc_arm", i), tdc_arm, 0);
        chk($sformatf("v%0d hold busy", i), busy, 1);
        for (int b = 0; b < v.bp; b++) begin
            start_req  = 1'b1;
            hit_start  = b[0];
            hit_stop   = !b[0];
            fine_start = FW'($urandom_range(0, 127));
            fine_stop  = FW'($urandom_range(0, 127));
            step();
            chk($sformatf("v%0d bp%0d res_valid", i, b), res_valid, 1);
            chk($sformatf("v%0d bp%0d res_coarse", i, b), res_coarse, v.exp_coarse);
            chk($sformatf("v%0d bp%0d res_fine_start", i, b), res_fine_start, v.exp_fs);
            chk($sformatf("v%0d bp%0d res_fine_stop", i, b), res_fine_stop, v.exp_fp);
            chk($sformatf("v%0d bp%0d tdc_arm", i, b), tdc_arm, 0);
            chk($sformatf("v%0d bp%0d tdc_clr", i, b), tdc_clr, 0);
        end
        start_req = 1'b0;
        hit_start = 1'b0;
        hit_stop  = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk($sformatf("v%0d clear tdc_clr", i), tdc_clr, 1);
        chk($sformatf("v%0d clear res_valid", i), res_valid, 0);
        chk($sformatf("v%0d clear cal_sel", i), cal_sel, 0);
        step();
        chk($sformatf("v%0d idle tdc_clr", i), tdc_clr, 0);
        chk($sformatf("v%0d idle busy", i), busy, 0);
        n_model = (n_model + 1) % 4;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " tdc_arm"}, tdc_arm, 0);
        chk({tag, " tdc_clr"}, tdc_clr, 0);
        chk({tag, " cal_sel"}, cal_sel, 0);
        chk({tag, " res_valid"}, res_valid, 0);
        chk({tag, " res_coarse"}, res_coarse, 0);
        chk({tag, " res_fine_start"}, res_fine_start, 0);
        chk({tag, " res_fine_stop"}, res_fine_stop, 0);
        chk({tag, " res_cal"}, res_cal, 0);
        chk({tag, " res_timeout"}, res_timeout, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        //              start stop xtra fs     fp     bp  lat coarse fs     fp     tmo
        vecs[0] = '{0,  5,  -1, 7'h12, 7'h40, 0,  6,  4'd5,  7'h12, 7'h40, 1'b0};
        vecs[1] = '{2,  2,  -1, 7'h03, 7'h7F, 0,  3,  4'd0,  7'h03, 7'h7F, 1'b0};
        vecs[2] = '{-1, 7,  -1, 7'h55, 7'h2A, 0,  20, 4'd0,  7'h00, 7'h00, 1'b1};
        vecs[3] = '{1,  2,  -1, 7'h21, 7'h22, 10, 3,  4'd1,  7'h21, 7'h22, 1'b0};
        vecs[4] = '{19, 19, -1, 7'h0A, 7'h0B, 0,  20, 4'd0,  7'h0A, 7'h0B, 1'b0};
        vecs[5] = '{0,  15, -1, 7'h7F, 7'h00, 0,  16, 4'd15, 7'h7F, 7'h00, 1'b0};
        vecs[6] = '{0,  -1, 5,  7'h11, 7'h66, 2,  17, 4'd0,  7'h00, 7'h00, 1'b1};
        vecs[7] = '{4,  9,  6,  7'h33, 7'h44, 0,  10, 4'd5,  7'h33, 7'h44, 1'b0};
        vecs[8] = '{5,  -1, -1, 7'h01, 7'h02, 0,  20, 4'd0,  7'h00, 7'h00, 1'b1};
        vecs[9] = '{5,  19, -1, 7'h5A, 7'h6B, 0,  20, 4'd14, 7'h5A, 7'h6B, 1'b0};

        rst        = 1'b0;
        start_req  = 1'b0;
        hit_start  = 1'b0;
        hit_stop   = 1'b0;
        fine_start = '0;
        fine_stop  = '0;
        res_ready  = 1'b0;
        #3;
        chk_all_zero("reset");
        repeat (3) @(negedge clk_in);
        rst = 1'b1;
        step();

        for (int i = 0; i < 10; i++) run_vec(i);

        // Async reset while waiting for the stop hit.
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        step();
        hit_start  = 1'b1;
        fine_start = 7'h3C;
        step();
        hit_start = 1'b0;
        step();
        step();
        chk("mid busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async reset");
        @(negedge clk_in);
        rst = 1'b1;
        n_model = 0;
        step();
        chk("post reset res_valid", res_valid, 0);
        chk("post reset busy", busy, 0);
        for (int i = 0; i < 4; i++) run_vec(i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
